// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the mac_acc14 multiply-accumulate stage.
//   - default widths for activation, weight, output and term counter
//   - state_t for the accept/hold controller
//   - sat_signed(): clip a signed value to a given width and report clipping
package mac_pkg;

  localparam int DEF_AWID = 10;
  localparam int DEF_WWID = 8;
  localparam int DEF_OWID = 14;
  localparam int DEF_CNTW = 10;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic signed [63:0] val;
    logic               clip;
  } sat_res_t;

  // Clip value into the signed range of 'width' bits (width <= 63).
  function automatic sat_res_t sat_signed(input logic signed [63:0] value,
                                          input int width);
    sat_res_t           r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      r.val  = hi;
      r.clip = 1'b1;
    end else if (value < lo) begin
      r.val  = lo;
      r.clip = 1'b1;
    end else begin
      r.val  = value;
      r.clip = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_sat.sv
// mac_sat: combinational arithmetic right shift followed by signed saturation.
// Ports:
//   acc_in   [ACCW-1:0] signed full-precision sum
//   sat_data [OWID-1:0] shifted and clipped result
//   sat_flag            1 when clipping changed the value
module mac_sat
  import mac_pkg::*;
#(
  parameter int ACCW  = 29,
  parameter int OWID  = DEF_OWID,
  parameter int SHIFT = 0
) (
  input  logic signed [ACCW-1:0] acc_in,
  output logic        [OWID-1:0] sat_data,
  output logic                   sat_flag
);

  logic signed [ACCW-1:0] shifted;
  logic signed [63:0]     shifted_ext;
  sat_res_t               res;
  logic                   unused_hi;

  // >>> on a signed operand rounds toward -inf, which is the intended behaviour.
  assign shifted     = acc_in >>> SHIFT;
  assign shifted_ext = {{(64 - ACCW){shifted[ACCW-1]}}, shifted};
  assign res         = sat_signed(shifted_ext, OWID);
  assign sat_data    = res.val[OWID-1:0];
  assign sat_flag    = res.clip;
  // Upper bits are just the sign extension of the clipped value.
  assign unused_hi   = ^res.val[63:OWID];

endmodule

// File: rtl/mac_acc14.sv
// mac_acc14: streaming multiply-accumulate for one neuron at a time.
// Accumulates unsigned-activation x signed-weight products at full precision,
// then shifts and saturates to a signed OWID-bit result on a valid/ready port.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input beat handshake (in_ready = state is ACC)
//   in_act [AWID-1:0]     unsigned activation
//   in_wgt [WWID-1:0]     signed weight
//   in_last               final term of the neuron
//   out_valid/out_ready   result handshake
//   out_data [OWID-1:0]   saturated signed sum
//   out_sat               result was clipped
//   out_ovf               result forced by the term-count limit
//
// state | meaning
// ACC   | accepting beats, accumulating
// HOLD  | result presented, waiting for out_ready
module mac_acc14
  import mac_pkg::*;
#(
  parameter int AWID  = DEF_AWID,
  parameter int WWID  = DEF_WWID,
  parameter int OWID  = DEF_OWID,
  parameter int CNTW  = DEF_CNTW,
  parameter int SHIFT = 0,
  parameter int ACCW  = AWID + WWID + 1 + CNTW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AWID-1:0] in_act,
  input  logic [WWID-1:0] in_wgt,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OWID-1:0] out_data,
  output logic            out_sat,
  output logic            out_ovf
);

  localparam int PW = AWID + WWID + 1;

  state_t                 state_q, state_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic        [CNTW-1:0] cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic        [OWID-1:0] out_data_q, out_data_d;
  logic                   out_sat_q, out_sat_d;
  logic                   out_ovf_q, out_ovf_d;

  logic signed [PW-1:0]   act_x;
  logic signed [PW-1:0]   wgt_x;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] sum;
  logic        [OWID-1:0] sat_data;
  logic                   sat_flag;
  logic                   cnt_full;
  logic                   is_final;

  // Both operands pre-extended to the product width so the truncated
  // PW-bit product is exact (activation zero-extended, weight sign-extended).
  assign act_x    = {{(WWID + 1){1'b0}}, in_act};
  assign wgt_x    = {{(AWID + 1){in_wgt[WWID-1]}}, in_wgt};
  assign prod     = act_x * wgt_x;
  assign prod_ext = {{(ACCW - PW){prod[PW-1]}}, prod};
  assign sum      = acc_q + prod_ext;

  assign cnt_full = &cnt_q;
  assign is_final = in_last | cnt_full;

  mac_sat #(
    .ACCW (ACCW),
    .OWID (OWID),
    .SHIFT(SHIFT)
  ) u_sat (
    .acc_in  (sum),
    .sat_data(sat_data),
    .sat_flag(sat_flag)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          if (is_final) begin
            out_data_d  = sat_data;
            out_sat_d   = sat_flag;
            out_ovf_d   = cnt_full & ~in_last;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = HOLD;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_ovf   = out_ovf_q;

endmodule
